// File: rtl/sam_mac_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sam_mac_sequencer
//
// Purpose:
//   Control and accumulation wrapper around an external shift-and-add
//   multiplier (SAM). Operand pairs arrive on a valid/ready stream. Each
//   accepted pair is latched and presented to the multiplier with a one-cycle
//   start pulse. The sequencer then waits for a rising edge of the
//   multiplier's Done level and adds the product into a running sum. When the
//   pair tagged In_Last has been added, the sum, the pair count and the
//   overflow flag are offered on a second valid/ready stream.
//
// Handshake semantics (both streams):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. A producer that raises valid keeps valid and its data stable until
//   that transfer. Here In_Ready depends only on the FSM state, never on
//   In_Valid. Acc_Valid likewise depends only on the FSM state, never on
//   Acc_Ready.
//
// Parameters:
//   WIDTH        operand width; the product is 2*WIDTH bits
//   ACC_WIDTH    accumulator width, must be >= 2*WIDTH
//   COUNT_WIDTH  width of the saturating accumulated-pair counter
//
// Ports:
//   Clock, Reset_n            rising-edge clock, async active-low reset
//   In_Valid/In_Ready         operand stream handshake
//   In_A, In_B, In_Last       multiplicand, multiplier, last-pair marker
//   Mul_Start                 one-cycle start pulse to the multiplier
//   Mul_A, Mul_B              latched operands, stable from start to next accept
//   Mul_R, Mul_Done           product and done level from the multiplier
//   Acc_Valid/Acc_Ready       result stream handshake
//   Acc_Out, Acc_Count        accumulated sum and number of pairs in it
//   Overflow                  sticky carry-out flag for the current sum
//   Dbg_State                 current FSM state, for observation only
//
// Build option:
//   SAM_MAC_SATURATE_EN  when defined, the accumulator clamps to all-ones on
//                        the first carry-out and stays clamped until the
//                        result is taken. When undefined it wraps modulo
//                        2^ACC_WIDTH. Overflow is set in both builds.
// ---------------------------------------------------------------------------
module sam_mac_sequencer #(
    parameter int WIDTH       = 8,
    parameter int ACC_WIDTH   = 24,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    input  logic                   In_Valid,
    output logic                   In_Ready,
    input  logic [WIDTH-1:0]       In_A,
    input  logic [WIDTH-1:0]       In_B,
    input  logic                   In_Last,
    output logic                   Mul_Start,
    output logic [WIDTH-1:0]       Mul_A,
    output logic [WIDTH-1:0]       Mul_B,
    input  logic [2*WIDTH-1:0]     Mul_R,
    input  logic                   Mul_Done,
    output logic                   Acc_Valid,
    input  logic                   Acc_Ready,
    output logic [ACC_WIDTH-1:0]   Acc_Out,
    output logic [COUNT_WIDTH-1:0] Acc_Count,
    output logic                   Overflow,
    output logic [2:0]             Dbg_State
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_ACCUM  = 3'd3;
    localparam logic [2:0] S_OUTPUT = 3'd4;

    // One extra bit so the carry-out of the accumulator add is visible.
    localparam int SUM_W = ACC_WIDTH + 1;

    logic [2:0]             state_q, state_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic                   last_q, last_d;
    logic                   done_prev_q, done_prev_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   ovf_q, ovf_d;

    logic                   in_fire;
    logic                   out_fire;
    logic                   done_rise;
    logic [SUM_W-1:0]       sum_ext;

    assign in_fire   = In_Valid && (state_q == S_IDLE);
    assign out_fire  = Acc_Ready && (state_q == S_OUTPUT);

    // Only a fresh 0->1 transition of Done counts. A Done level still high
    // from the previous product is therefore never taken as a new result.
    assign done_rise = Mul_Done && !done_prev_q;

    assign sum_ext   = {1'b0, acc_q} + SUM_W'(prod_q);

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        last_d      = last_q;
        done_prev_d = Mul_Done;
        prod_d      = prod_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_fire) begin
                    a_d     = In_A;
                    b_d     = In_B;
                    last_d  = In_Last;
                    state_d = S_START;
                end
            end

            S_START: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (done_rise) begin
                    prod_d  = Mul_R;
                    state_d = S_ACCUM;
                end
            end

            S_ACCUM: begin
                if (count_q != {COUNT_WIDTH{1'b1}}) begin
                    count_d = count_q + COUNT_WIDTH'(1);
                end
`ifdef SAM_MAC_SATURATE_EN
                // Once clamped, the sum stays at all-ones until it is taken.
                if (ovf_q || sum_ext[ACC_WIDTH]) begin
                    acc_d = {ACC_WIDTH{1'b1}};
                end else begin
                    acc_d = sum_ext[ACC_WIDTH-1:0];
                end
`else
                acc_d = sum_ext[ACC_WIDTH-1:0];
`endif
                if (sum_ext[ACC_WIDTH]) begin
                    ovf_d = 1'b1;
                end
                state_d = last_q ? S_OUTPUT : S_IDLE;
            end

            S_OUTPUT: begin
                // Result registers are untouched here, so they hold while
                // the consumer stalls.
                if (out_fire) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            last_q      <= 1'b0;
            done_prev_q <= 1'b0;
            prod_q      <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            last_q      <= last_d;
            done_prev_q <= done_prev_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: all decoded from registers, no input-to-output paths.
    // -----------------------------------------------------------------------
    assign In_Ready  = (state_q == S_IDLE);
    assign Mul_Start = (state_q == S_START);
    assign Mul_A     = a_q;
    assign Mul_B     = b_q;
    assign Acc_Valid = (state_q == S_OUTPUT);
    assign Acc_Out   = acc_q;
    assign Acc_Count = count_q;
    assign Overflow  = ovf_q;
    assign Dbg_State = state_q;

endmodule

// File: tb/tb_sam_mac_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_sam_mac_sequencer
//
// Bench for sam_mac_sequencer with ACC_WIDTH=16 so that overflow is reachable.
// A behavioural multiplier with random latency answers Mul_Start. Sometimes
// it drops Done one cycle late, so a stale Done level is seen during WAIT.
// The reference model works on transactions: when a pair is accepted, when
// its product becomes available, and what the sum must be. From those events
// it derives the cycle-level expectations.
// ---------------------------------------------------------------------------
module tb_sam_mac_sequencer;

    localparam int WIDTH       = 8;
    localparam int ACC_WIDTH   = 16;
    localparam int COUNT_WIDTH = 8;
    localparam int RES_W       = 1 + COUNT_WIDTH + ACC_WIDTH;
    localparam longint ACC_MAX = (64'd1 << ACC_WIDTH) - 1;
    localparam longint CNT_MAX = (64'd1 << COUNT_WIDTH) - 1;

    // ---------------- clock / reset ----------------
    logic                   Clock = 1'b0;
    logic                   Reset_n = 1'b0;
    always #5 Clock = ~Clock;

    logic                   In_Valid;
    logic                   In_Ready;
    logic [WIDTH-1:0]       In_A;
    logic [WIDTH-1:0]       In_B;
    logic                   In_Last;
    logic                   Mul_Start;
    logic [WIDTH-1:0]       Mul_A;
    logic [WIDTH-1:0]       Mul_B;
    logic [2*WIDTH-1:0]     Mul_R;
    logic                   Mul_Done;
    logic                   Acc_Valid;
    logic                   Acc_Ready;
    logic [ACC_WIDTH-1:0]   Acc_Out;
    logic [COUNT_WIDTH-1:0] Acc_Count;
    logic                   Overflow;
    logic [2:0]             Dbg_State;

    sam_mac_sequencer #(
        .WIDTH      (WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .COUNT_WIDTH(COUNT_WIDTH)
    ) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .In_A     (In_A),
        .In_B     (In_B),
        .In_Last  (In_Last),
        .Mul_Start(Mul_Start),
        .Mul_A    (Mul_A),
        .Mul_B    (Mul_B),
        .Mul_R    (Mul_R),
        .Mul_Done (Mul_Done),
        .Acc_Valid(Acc_Valid),
        .Acc_Ready(Acc_Ready),
        .Acc_Out  (Acc_Out),
        .Acc_Count(Acc_Count),
        .Overflow (Overflow),
        .Dbg_State(Dbg_State)
    );

    // ---------------- counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural multiplier ----------------
    int               mul_lat_min = 1;
    int               mul_lat_max = 4;
    int               mul_cnt     = 0;
    logic             mul_stale   = 1'b0;
    logic             mul_st_s;
    logic [WIDTH-1:0] mul_a_s, mul_b_s, mul_a, mul_b;

    initial begin
        Mul_Done = 1'b0;
        Mul_R    = '0;
        mul_a    = '0;
        mul_b    = '0;
    end

    always begin
        @(negedge Clock);
        mul_st_s = Mul_Start;
        mul_a_s  = Mul_A;
        mul_b_s  = Mul_B;
        @(posedge Clock);
        #1;
        if (!Reset_n) begin
            Mul_Done  = 1'b0;
            Mul_R     = '0;
            mul_cnt   = 0;
            mul_stale = 1'b0;
        end else if (mul_st_s) begin
            mul_a   = mul_a_s;
            mul_b   = mul_b_s;
            mul_cnt = $urandom_range(mul_lat_max, mul_lat_min);
            if (Mul_Done && ($urandom_range(0, 1) == 1)) begin
                mul_stale = 1'b1;
            end else begin
                Mul_Done = 1'b0;
            end
        end else if (mul_stale) begin
            Mul_Done  = 1'b0;
            mul_stale = 1'b0;
        end else if (mul_cnt > 0) begin
            mul_cnt--;
            if (mul_cnt == 0) begin
                Mul_R    = mul_a * mul_b;
                Mul_Done = 1'b1;
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [RES_W-1:0] exp_q[$];

    int               cyc        = 0;
    logic             busy       = 1'b0;
    logic             awaiting   = 1'b0;
    logic             out_pend   = 1'b0;
    int               start_cyc  = -10;
    int               free_at    = -10;
    int               valid_from = -10;
    longint           cur_a, cur_b;
    logic             cur_last;
    longint           m_sum = 0;
    longint           m_cnt = 0;
    logic             m_ovf = 1'b0;
    logic             prev_done = 1'b0;
    logic             prev_hold = 1'b0;
    logic [2:0]       prev_dbg;

    int               hs_count    = 0;
    int               starts_seen = 0;
    int               hold_cycles = 0;
    int               last_hold   = 0;
    longint           res_acc, res_cnt;
    logic             res_ovf;

    logic             e_ready, e_start, e_valid;
    logic [RES_W-1:0] e_res;
    longint           nx;

    always @(negedge Clock) begin
        cyc++;
        if (!Reset_n) begin
            busy     = 1'b0;
            awaiting = 1'b0;
            out_pend = 1'b0;
            exp_q.delete();
            m_sum    = 0;
            m_cnt    = 0;
            m_ovf    = 1'b0;
            hold_cycles = 0;
            prev_hold   = 1'b0;
            chk("rst_in_ready",  In_Ready,  1);
            chk("rst_mul_start", Mul_Start, 0);
            chk("rst_acc_valid", Acc_Valid, 0);
            chk("rst_acc_out",   Acc_Out,   0);
            chk("rst_acc_count", Acc_Count, 0);
            chk("rst_overflow",  Overflow,  0);
        end else begin
            if (busy && !awaiting && !out_pend && cyc == free_at) busy = 1'b0;
            e_ready = !busy;
            e_start = busy && (cyc == start_cyc);
            e_valid = out_pend && (cyc >= valid_from);

            chk("in_ready",  In_Ready,  e_ready);
            chk("mul_start", Mul_Start, e_start);
            chk("acc_valid", Acc_Valid, e_valid);
            if (Mul_Start) starts_seen++;

            if (e_start) begin
                chk("mul_a", Mul_A, cur_a);
                chk("mul_b", Mul_B, cur_b);
            end

            if (e_valid) begin
                e_res = exp_q[0];
                chk("acc_out",   Acc_Out,   e_res[ACC_WIDTH-1:0]);
                chk("acc_count", Acc_Count, e_res[ACC_WIDTH +: COUNT_WIDTH]);
                chk("overflow",  Overflow,  e_res[RES_W-1]);
                if (prev_hold) chk("state_hold", Dbg_State, prev_dbg);
                if (!Acc_Ready) hold_cycles++;
            end
            prev_hold = e_valid && !Acc_Ready;
            prev_dbg  = Dbg_State;

            // Acceptance of a new pair.
            if (e_ready && In_Valid) begin
                busy      = 1'b1;
                awaiting  = 1'b1;
                start_cyc = cyc + 1;
                cur_a     = In_A;
                cur_b     = In_B;
                cur_last  = In_Last;
            end

            // Product becomes available on a fresh Done edge after start.
            if (awaiting && cyc > start_cyc && Mul_Done && !prev_done) begin
                awaiting = 1'b0;
                nx = m_sum + cur_a * cur_b;
                if (nx > ACC_MAX) begin
                    m_ovf = 1'b1;
`ifdef SAM_MAC_SATURATE_EN
                    m_sum = ACC_MAX;
`else
                    m_sum = nx - ACC_MAX - 1;
`endif
                end else begin
                    m_sum = nx;
                end
                if (m_cnt < CNT_MAX) m_cnt++;
                if (cur_last) begin
                    exp_q.push_back({m_ovf, m_cnt[COUNT_WIDTH-1:0], m_sum[ACC_WIDTH-1:0]});
                    out_pend   = 1'b1;
                    valid_from = cyc + 2;
                end else begin
                    free_at = cyc + 2;
                end
            end

            // Result handshake.
            if (e_valid && Acc_Ready) begin
                res_acc = Acc_Out;
                res_cnt = Acc_Count;
                res_ovf = Overflow;
                void'(exp_q.pop_front());
                m_sum     = 0;
                m_cnt     = 0;
                m_ovf     = 1'b0;
                out_pend  = 1'b0;
                free_at   = cyc + 1;
                last_hold = hold_cycles;
                hold_cycles = 0;
                hs_count++;
            end
        end
        prev_done = Mul_Done;
    end

    // ---------------- drivers ----------------
    logic rand_ready_en = 1'b0;
    int   last_stall    = 0;

    always @(posedge Clock) begin
        #1;
        if (rand_ready_en) Acc_Ready = ($urandom_range(0, 1) == 1);
    end

    task automatic send_pair(input int a, input int b, input logic last);
        int t;
        @(posedge Clock);
        #1;
        In_Valid = 1'b1;
        In_A     = a[WIDTH-1:0];
        In_B     = b[WIDTH-1:0];
        In_Last  = last;
        t = 0;
        @(negedge Clock);
        while (!In_Ready && t < 300) begin
            t++;
            @(negedge Clock);
        end
        last_stall = t;
        if (!In_Ready) chk("accept_timeout", t, -1);
        @(posedge Clock);
        #1;
        In_Valid = 1'b0;
        In_Last  = 1'b0;
    endtask

    task automatic wait_hs(input int target);
        int t;
        t = 0;
        while (hs_count < target && t < 600) begin
            @(posedge Clock);
            t++;
        end
        if (hs_count < target) chk("result_timeout", hs_count, target);
        @(posedge Clock);
        #1;
    endtask

    // ---------------- directed + random sequence ----------------
    int h0;
    int s0;
    int n_last;
    int t_wait;
    logic lst;

    initial begin
        In_Valid  = 1'b0;
        In_A      = '0;
        In_B      = '0;
        In_Last   = 1'b0;
        Acc_Ready = 1'b1;
        Reset_n   = 1'b0;
        repeat (3) @(posedge Clock);
        #2 Reset_n = 1'b1;

        // Single pair.
        h0 = hs_count;
        s0 = starts_seen;
        send_pair(12, 10, 1'b1);
        wait_hs(h0 + 1);
        chk("single_acc",    res_acc, 120);
        chk("single_count",  res_cnt, 1);
        chk("single_ovf",    res_ovf, 0);
        chk("single_starts", starts_seen - s0, 1);

        // Three-pair sum.
        h0 = hs_count;
        send_pair(12, 10, 1'b0);
        send_pair(150, 0, 1'b0);
        send_pair(255, 250, 1'b1);
        wait_hs(h0 + 1);
        chk("three_acc",   res_acc, 63870);
        chk("three_count", res_cnt, 3);

        // Result back-pressure for 5 cycles.
        h0 = hs_count;
        Acc_Ready = 1'b0;
        send_pair(7, 9, 1'b1);
        t_wait = 0;
        @(negedge Clock);
        while (!Acc_Valid && t_wait < 100) begin
            t_wait++;
            @(negedge Clock);
        end
        if (!Acc_Valid) chk("bp_valid_timeout", t_wait, -1);
        repeat (4) @(negedge Clock);
        @(posedge Clock);
        #1 Acc_Ready = 1'b1;
        wait_hs(h0 + 1);
        chk("bp_hold_cycles", last_hold, 5);
        chk("bp_acc", res_acc, 63);
        h0 = hs_count;
        send_pair(3, 4, 1'b1);
        wait_hs(h0 + 1);
        chk("bp_next_from_zero", res_acc, 12);

        // Overflow.
        h0 = hs_count;
        send_pair(255, 255, 1'b0);
        send_pair(255, 255, 1'b1);
        wait_hs(h0 + 1);
`ifdef SAM_MAC_SATURATE_EN
        chk("ovf_acc", res_acc, 65535);
`else
        chk("ovf_acc", res_acc, 64514);
`endif
        chk("ovf_flag",  res_ovf, 1);
        chk("ovf_count", res_cnt, 2);

        // Input held valid while the sequencer is busy.
        h0 = hs_count;
        send_pair(5, 6, 1'b0);
        send_pair(2, 3, 1'b1);
        chk("stall_waited", (last_stall >= 3) ? 1 : 0, 1);
        wait_hs(h0 + 1);
        chk("stall_acc", res_acc, 36);

        // Reset while waiting for the multiplier.
        mul_lat_min = 12;
        mul_lat_max = 12;
        h0 = hs_count;
        send_pair(9, 9, 1'b1);
        repeat (3) @(posedge Clock);
        #2 Reset_n = 1'b0;
        repeat (2) @(posedge Clock);
        #2 Reset_n = 1'b1;
        @(negedge Clock);
        chk("post_rst_ready", In_Ready, 1);
        chk("post_rst_no_result", hs_count, h0);
        mul_lat_min = 1;
        mul_lat_max = 4;
        h0 = hs_count;
        send_pair(3, 4, 1'b1);
        wait_hs(h0 + 1);
        chk("post_rst_acc", res_acc, 12);
        chk("post_rst_count", res_cnt, 1);

        // Pair counter saturates instead of wrapping.
        mul_lat_min = 1;
        mul_lat_max = 2;
        h0 = hs_count;
        for (int i = 0; i < 260; i++) send_pair(1, 1, (i == 259));
        wait_hs(h0 + 1);
        chk("sat_count", res_cnt, 255);
        chk("sat_acc",   res_acc, 260);

        // Randomized traffic with random result back-pressure.
        mul_lat_min = 1;
        mul_lat_max = 5;
        rand_ready_en = 1'b1;
        h0 = hs_count;
        n_last = 0;
        for (int i = 0; i < 60; i++) begin
            lst = ($urandom_range(0, 3) == 0) || (i == 59);
            if (lst) n_last++;
            send_pair($urandom_range(0, 255), $urandom_range(0, 255), lst);
        end
        wait_hs(h0 + n_last);
        rand_ready_en = 1'b0;
        Acc_Ready = 1'b1;
        repeat (4) @(posedge Clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
